// File: rtl/riscv_core_pkg.sv
// riscv_core_pkg: shared constants for the multicycle 16-bit core.
// Holds opcodes, FSM state encoding, instruction field positions, ALU op codes,
// and the opcode decode helpers used by the core and its ALU.
// Optional feature macro: RISCV_MUL_EN (opcode 8 decodes as MUL when defined).
package riscv_core_pkg;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_ADDI = 4'h4;
    localparam logic [3:0] OP_LW   = 4'h5;
    localparam logic [3:0] OP_SW   = 4'h6;
    localparam logic [3:0] OP_BEQ  = 4'h7;
    localparam logic [3:0] OP_MUL  = 4'h8;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    localparam int OP_LSB  = 12;
    localparam int RD_LSB  = 9;
    localparam int RS1_LSB = 6;
    localparam int RS2_LSB = 3;
    localparam int IMM_W   = 6;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_MUL = 3'd4;

    // Address-forming instructions (ADDI/LW/SW) all reuse the adder.
    function automatic logic [2:0] alu_sel(input logic [3:0] op);
        case (op)
            OP_ADD, OP_ADDI, OP_LW, OP_SW: return ALU_ADD;
            OP_SUB: return ALU_SUB;
            OP_AND: return ALU_AND;
            OP_OR:  return ALU_OR;
            OP_MUL: return ALU_MUL;
            default: return ALU_ADD;
        endcase
    endfunction

    function automatic logic op_legal(input logic [3:0] op);
`ifdef RISCV_MUL_EN
        return op <= OP_MUL || op == OP_HALT;
`else
        return op <= OP_BEQ || op == OP_HALT;
`endif
    endfunction

endpackage

// File: rtl/riscv_alu_param.sv
// riscv_alu_param: combinational XLEN-wide ALU for the multicycle core.
// Ports: op (ALU op code), a/b (operands), y (result, modulo 2^XLEN), eq (a == b).
// Optional feature macro: RISCV_MUL_EN (multiplier present when defined).
module riscv_alu_param
    import riscv_core_pkg::*;
#(
    parameter int XLEN = 16
) (
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] y,
    output logic            eq
);

    logic [XLEN-1:0] prod;

`ifdef RISCV_MUL_EN
    assign prod = a * b;
`else
    assign prod = '0;
`endif

    always_comb begin
        y = op == ALU_SUB ? a - b :
            op == ALU_AND ? a & b :
            op == ALU_OR  ? a | b :
            op == ALU_MUL ? prod  : a + b;
    end

    assign eq = a == b;

endmodule

// File: rtl/riscv_core_multicycle.sv
// riscv_core_multicycle: multicycle 16-bit ISA core, FSM FETCH/DECODE/EXEC/MEM/WB/HALT.
// Ports: clk; rst_n (async, active-HIGH); imem_addr/imem_rdata/imem_valid (fetch);
// dmem_req/dmem_we/dmem_addr/dmem_wdata/dmem_rdata/dmem_ack (data access, held to ack);
// retire/illegal (one-cycle pulses); halted (sticky level).
// Optional feature macro: RISCV_MUL_EN (opcode 8 = MUL; otherwise illegal).
module riscv_core_multicycle
    import riscv_core_pkg::*;
#(
    parameter int XLEN    = 16,
    parameter int IADDR_W = 8,
    parameter int DADDR_W = 9,
    parameter int NREG    = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [IADDR_W-1:0] imem_addr,
    input  logic [15:0]        imem_rdata,
    input  logic               imem_valid,
    output logic               dmem_req,
    output logic               dmem_we,
    output logic [DADDR_W-1:0] dmem_addr,
    output logic [XLEN-1:0]    dmem_wdata,
    input  logic [XLEN-1:0]    dmem_rdata,
    input  logic               dmem_ack,
    output logic               retire,
    output logic               illegal,
    output logic               halted
);

    logic [2:0]         state;
    logic [IADDR_W-1:0] pc, pc_inc, br_off;
    logic [15:0]        ir;
    logic [XLEN-1:0]    a, b, imm, y, alu_b, alu_y;
    logic [XLEN-1:0]    regs [NREG];
    logic [3:0]         op;
    logic [2:0]         rd, rs1, rs2;
    logic               eq, use_imm;

    assign op      = ir[OP_LSB +: 4];
    assign rd      = ir[RD_LSB +: 3];
    assign rs1     = ir[RS1_LSB +: 3];
    assign rs2     = ir[RS2_LSB +: 3];
    assign pc_inc  = pc + IADDR_W'(1);
    assign br_off  = {{(IADDR_W-IMM_W){ir[IMM_W-1]}}, ir[IMM_W-1:0]};
    assign use_imm = op == OP_ADDI || op == OP_LW || op == OP_SW;
    assign alu_b   = use_imm ? imm : b;

    riscv_alu_param #(.XLEN(XLEN)) alu (
        .op(alu_sel(op)),
        .a (a),
        .b (alu_b),
        .y (alu_y),
        .eq(eq)
    );

    // Memory-side outputs are pure decodes of state so an async reset drops them at once.
    assign imem_addr  = pc;
    assign dmem_req   = state == S_MEM;
    assign dmem_we    = dmem_req && op == OP_SW;
    assign dmem_addr  = dmem_req ? y[DADDR_W-1:0] : '0;
    assign dmem_wdata = dmem_req ? b : '0;
    assign halted     = state == S_HALT;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state   <= S_FETCH;
            pc      <= '0;
            ir      <= '0;
            a       <= '0;
            b       <= '0;
            imm     <= '0;
            y       <= '0;
            retire  <= 1'b0;
            illegal <= 1'b0;
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else begin
            retire  <= 1'b0;
            illegal <= 1'b0;
            case (state)
                S_FETCH: begin
                    if (imem_valid) begin
                        ir    <= imem_rdata;
                        state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    // SW stores R[rd] and BEQ compares R[rd], so B picks rd for those.
                    a   <= regs[rs1];
                    b   <= (op == OP_SW || op == OP_BEQ) ? regs[rd] : regs[rs2];
                    imm <= {{(XLEN-IMM_W){ir[IMM_W-1]}}, ir[IMM_W-1:0]};
                    if (op == OP_HALT) begin
                        state <= S_HALT;
                    end else if (!op_legal(op)) begin
                        illegal <= 1'b1;
                        pc      <= pc_inc;
                        state   <= S_FETCH;
                    end else begin
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    y <= alu_y;
                    if (op == OP_BEQ) begin
                        pc     <= eq ? pc + br_off : pc_inc;
                        retire <= 1'b1;
                        state  <= S_FETCH;
                    end else begin
                        state <= (op == OP_LW || op == OP_SW) ? S_MEM : S_WB;
                    end
                end
                S_MEM: begin
                    if (dmem_ack) begin
                        if (op == OP_SW) begin
                            pc     <= pc_inc;
                            retire <= 1'b1;
                            state  <= S_FETCH;
                        end else begin
                            y     <= dmem_rdata;
                            state <= S_WB;
                        end
                    end
                end
                S_WB: begin
                    if (rd != 3'd0) regs[rd] <= y;
                    pc     <= pc_inc;
                    retire <= 1'b1;
                    state  <= S_FETCH;
                end
                default: state <= S_HALT;
            endcase
        end
    end

endmodule

// File: doc/riscv_core_multicycle.md
Name: riscv_core_multicycle

Overview:
- Parametrised multicycle successor to the single-cycle 4-instruction core.
- Runs a 16-bit ISA through an explicit FSM: FETCH, DECODE, EXEC, MEM, WB, HALT.
- Uses valid/ack handshakes to instruction ROM and data RAM, so memories may stall.
- Sits between the instruction ROM and the data RAM in the SoC top level.

Parameters:
- XLEN, 16: datapath and register width (min 8).
- IADDR_W, 8: instruction address width; PC wraps modulo 2^IADDR_W.
- DADDR_W, 9: data address width; address = ALU result[DADDR_W-1:0].
- NREG, 8: register count; fixed by the 3-bit index fields. x0 reads 0, writes ignored.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-HIGH reset (1 = reset). Name kept for codebase consistency.
- imem_addr  out  IADDR_W  fetch address, equals PC.
- imem_rdata  in  16  instruction word.
- imem_valid  in  1  imem_rdata valid this cycle.
- dmem_req  out  1  data access request; held until ack.
- dmem_we  out  1  1 = store, 0 = load; valid while dmem_req.
- dmem_addr  out  DADDR_W  data address.
- dmem_wdata  out  XLEN  store data.
- dmem_rdata  in  XLEN  load data; valid with dmem_ack.
- dmem_ack  in  1  access complete, single-cycle pulse.
- retire  out  1  one-cycle pulse per completed instruction.
- illegal  out  1  one-cycle pulse on an undefined opcode.
- halted  out  1  level; core stopped.

Behaviour:
- Encoding: [15:12] op, [11:9] rd, [8:6] rs1, [5:3] rs2, [5:0] imm6, sign-extended to XLEN.
- Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 ADDI rd=rs1+imm, 5 LW rd=M[rs1+imm], 6 SW M[rs1+imm]=rd, 7 BEQ (if rd==rs1 then PC+=imm else PC+1), F HALT. All others are illegal.
- Arithmetic is modulo 2^XLEN with no flags.
- Reset (async, immediate): state=FETCH, PC=0, all registers 0, all outputs 0.
- FETCH: imem_addr=PC. If imem_valid, latch IR and go to DECODE; otherwise stay.
- DECODE: latch A=R[rs1], B=R[rs2] (R[rd] for SW/BEQ), imm.
  - Illegal opcode: pulse illegal, PC+1, go to FETCH. No retire.
  - HALT: go to HALT.
- EXEC: compute ALU result.
  - BEQ: update PC, pulse retire, go to FETCH.
  - LW/SW: go to MEM.
  - Others: go to WB.
- MEM: dmem_req=1 with addr/we/wdata stable until dmem_ack.
  - ack is accepted in the same cycle dmem_req is first asserted (zero-wait memory allowed).
  - On ack: LW latches dmem_rdata and goes to WB; SW does PC+1, pulses retire, goes to FETCH.
  - dmem_req drops the cycle after ack.
- WB: write rd (skipped if rd=0), PC+1, pulse retire, go to FETCH.
- HALT: halted=1 and sticky; ignores imem/dmem. Leaves only via reset.
- Latency with zero-wait memories, in cycles:
  - R-type/ADDI: 4.
  - LW: 5.
  - SW: 4.
  - BEQ: 3.
  - Each imem/dmem wait cycle adds 1.
- Boundaries:
  - PC at 2^IADDR_W-1 +1 wraps to 0.
  - A BEQ target wraps the same way.
  - imem_valid outside FETCH is ignored.
  - dmem_ack outside MEM is ignored.
  - Reset during MEM drops dmem_req immediately.

Optional Feature:
- RISCV_MUL_EN defined: opcode 8 is MUL, rd = low XLEN bits of rs1*rs2. Same 4-cycle timing as ADD.
- Undefined: opcode 8 is illegal.

Decomposition:
- Package riscv_core_pkg holds:
  - opcode constants;
  - FSM state encoding;
  - instruction field bit positions;
  - ALU op codes.
- One natural sub-module: riscv_alu_param, combinational and XLEN-parametrised. It does add/sub/and/or/mul and the equality compare.

Test Plan:
- ADDI x1,x0,5; ADDI x2,x0,-3; ADD x3,x1,x2 with imem_valid always 1 -> x3=2, retire every 4th cycle.
- SW x3,[x0+4], then LW x4,[x0+4], with ack delayed 2 cycles -> dmem_req high 3 cycles, addr=4, wdata=2, x4=2, LW total 7 cycles.
- BEQ x1,x1,-2 at PC=10 -> PC=8. BEQ x1,x2 at PC=10 -> PC=11. Each takes 3 cycles.
- Opcode 0xA at PC=3 -> illegal pulse, no retire, no register write, next fetch at 4. Opcode 8 with MUL_EN: 5*(-3) -> 0xFFF1.
- HALT -> halted=1 from the next cycle, imem_addr frozen. Assert rst_n=1 -> PC=0, halted=0 asynchronously.
- PC=255 with IADDR_W=8 -> next fetch at 0. Reset asserted mid-MEM -> dmem_req=0 within the same cycle.
